// File: rtl/unipolar_rz_receiver.sv
// ============================================================================
// Module      : unipolar_rz_receiver
// Description : Unipolar return-to-zero (WS2812-style) line decoder. Measures
//               high-pulse widths, classifies them as 0/1 against the midpoint
//               of the nominal widths, assembles LSB-first words and flags
//               frame ends (long low gaps) and protocol violations.
//               Optional macro UNIPOLAR_RZ_GLITCH_FILTER_EN inserts a
//               3-sample stability filter after the synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module unipolar_rz_receiver #(
    // Defaults describe a 10 MHz reference setup; instances override them.
    parameter int  DATA_WIDTH     = 8,
    parameter int  CLOCK_RATE     = 10_000_000,
    parameter real ZERO_HIGH_TIME = 400.0e-9,
    parameter real ONE_HIGH_TIME  = 800.0e-9,
    parameter real RESET_TIME     = 50.0e-6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  frame_end,
    output logic                  error,
    output logic                  busy
);

    // Cycle-domain timing constants, rounded to the nearest clock.
    localparam int c_ZH       = $rtoi(real'(CLOCK_RATE) * ZERO_HIGH_TIME + 0.5);
    localparam int c_OH       = $rtoi(real'(CLOCK_RATE) * ONE_HIGH_TIME + 0.5);
    localparam int c_RST      = $rtoi(real'(CLOCK_RATE) * RESET_TIME + 0.5);
    localparam int c_THRESH   = (c_ZH + c_OH) / 2;
    localparam int c_MAX_HIGH = 2 * c_OH;
    localparam int c_LIMIT    = (c_RST > c_MAX_HIGH) ? c_RST : c_MAX_HIGH;
    localparam int c_CNT_W    = $clog2(c_LIMIT + 1);
    localparam int c_BC_W     = $clog2(DATA_WIDTH);

    localparam logic [c_CNT_W-1:0] c_RST_C    = c_CNT_W'(c_RST);
    localparam logic [c_CNT_W-1:0] c_THRESH_C = c_CNT_W'(c_THRESH);
    localparam logic [c_CNT_W-1:0] c_MAXH_C   = c_CNT_W'(c_MAX_HIGH);
    localparam logic [c_CNT_W-1:0] c_LIMIT_C  = c_CNT_W'(c_LIMIT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_BC_W-1:0]  c_BC_ONE   = c_BC_W'(1);
    localparam logic [c_BC_W-1:0]  c_BC_LAST  = c_BC_W'(DATA_WIDTH - 1);

    localparam logic [1:0] c_ST_SYNC = 2'd0;
    localparam logic [1:0] c_ST_LOW  = 2'd1;
    localparam logic [1:0] c_ST_HIGH = 2'd2;

    logic                  r_sync1, r_sync2, w_level;
    logic                  r_prev, r_rise, r_fall;
    logic [1:0]            r_state, w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [c_BC_W-1:0]     r_bitcnt, w_bitcnt_nxt;
    logic [DATA_WIDTH-2:0] r_sreg, w_sreg_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt, w_shift;
    logic                  r_valid, r_frame_end, r_error, r_busy, r_seen;
    logic                  w_valid_nxt, w_fe_nxt, w_err_nxt, w_seen_nxt, w_busy_nxt;
    logic                  w_bit;

`ifdef UNIPOLAR_RZ_GLITCH_FILTER_EN
    logic r_hist0, r_hist1, r_held;

    // Stability filter: the level follows the input only after 3 equal samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hist0 <= 1'b0;
            r_hist1 <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_hist0 <= r_sync2;
            r_hist1 <= r_hist0;
            r_held  <= w_level;
        end
    end

    assign w_level = ((r_sync2 == r_hist0) && (r_hist0 == r_hist1)) ? r_sync2 : r_held;
`else
    assign w_level = r_sync2;
`endif

    // Synchronize the pin and register rise/fall together with the level they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= line;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
            r_rise  <= w_level & ~r_prev;
            r_fall  <= ~w_level & r_prev;
        end
    end

    // Saturating counter increment shared by all states.
    assign w_cnt_inc = (r_cnt == c_LIMIT_C) ? r_cnt : r_cnt + c_CNT_ONE;
    assign w_bit     = (r_cnt > c_THRESH_C);
    assign w_shift   = {w_bit, r_sreg};

    // Next-state decode for the SYNC / LOW / HIGH line tracker.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bitcnt_nxt = r_bitcnt;
        w_sreg_nxt   = r_sreg;
        w_data_nxt   = r_data;
        w_valid_nxt  = 1'b0;
        w_fe_nxt     = 1'b0;
        w_err_nxt    = 1'b0;
        w_seen_nxt   = r_seen;
        case (r_state)
            c_ST_SYNC: begin
                w_bitcnt_nxt = '0;
                if (r_prev) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= c_RST_C) begin
                        w_state_nxt = c_ST_LOW;
                    end
                end
            end
            c_ST_LOW: begin
                if (r_rise) begin
                    // The rising sample itself is the first high cycle.
                    w_state_nxt = c_ST_HIGH;
                    w_cnt_nxt   = c_CNT_ONE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    // Fire once, on the cycle the low run first reaches RST.
                    if ((w_cnt_inc == c_RST_C) && (r_cnt != c_RST_C)) begin
                        if (r_bitcnt == '0) begin
                            if (r_seen) begin
                                w_fe_nxt   = 1'b1;
                                w_seen_nxt = 1'b0;
                            end
                        end else begin
                            // Gap inside a word; the count already satisfies SYNC.
                            w_err_nxt    = 1'b1;
                            w_bitcnt_nxt = '0;
                            w_state_nxt  = c_ST_SYNC;
                        end
                    end
                end
            end
            c_ST_HIGH: begin
                if (r_fall) begin
                    w_state_nxt = c_ST_LOW;
                    w_cnt_nxt   = c_CNT_ONE;
                    w_sreg_nxt  = w_shift[DATA_WIDTH-1:1];
                    if (r_bitcnt == c_BC_LAST) begin
                        w_data_nxt   = w_shift;
                        w_valid_nxt  = 1'b1;
                        w_bitcnt_nxt = '0;
                        w_seen_nxt   = 1'b1;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + c_BC_ONE;
                    end
                end else if (w_cnt_inc >= c_MAXH_C) begin
                    w_err_nxt    = 1'b1;
                    w_bitcnt_nxt = '0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = c_ST_SYNC;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt  = c_ST_SYNC;
                w_cnt_nxt    = '0;
                w_bitcnt_nxt = '0;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == c_ST_HIGH) ||
                        ((w_state_nxt == c_ST_LOW) && (w_bitcnt_nxt != '0));

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_SYNC;
            r_cnt       <= '0;
            r_bitcnt    <= '0;
            r_sreg      <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
            r_error     <= 1'b0;
            r_busy      <= 1'b0;
            r_seen      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_sreg      <= w_sreg_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_end <= w_fe_nxt;
            r_error     <= w_err_nxt;
            r_busy      <= w_busy_nxt;
            r_seen      <= w_seen_nxt;
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_end = r_frame_end;
    assign error     = r_error;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_unipolar_rz_receiver.sv
// ============================================================================
// Module      : tb_unipolar_rz_receiver
// Description : Randomized self-checking bench for unipolar_rz_receiver with a
//               pulse-level reference model (segments of high/low cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_unipolar_rz_receiver;

    localparam int c_RST  = 500;
    localparam int c_MAXH = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       line  = 1'b0;
    logic [7:0] data;
    logic       valid, frame_end, error, busy;

    unipolar_rz_receiver #(
        .DATA_WIDTH     (8),
        .CLOCK_RATE     (10_000_000),
        .ZERO_HIGH_TIME (400.0e-9),
        .ONE_HIGH_TIME  (800.0e-9),
        .RESET_TIME     (50.0e-6)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .line      (line),
        .data      (data),
        .valid     (valid),
        .frame_end (frame_end),
        .error     (error),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Observed and predicted events for the current scenario.
    logic [7:0] act_data[$];
    logic [7:0] exp_data[$];
    int act_fe = 0, act_err = 0, exp_fe = 0, exp_err = 0;

    // Reference model state: sync acquired, low run lengths, pending bits.
    bit m_synced = 1'b0;
    int m_lowrun = 0;
    int m_lowcnt = 0;
    bit m_bits[$];
    bit m_seen = 1'b0;

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (valid === 1'b1)     act_data.push_back(data);
            if (frame_end === 1'b1) act_fe++;
            if (error === 1'b1)     act_err++;
        end
    end

    task automatic m_reset();
        m_synced = 1'b0;
        m_lowrun = 0;
        m_lowcnt = 0;
        m_bits.delete();
        m_seen = 1'b0;
    endtask

    task automatic m_low(int n);
        int old;
        if (!m_synced) begin
            m_lowrun += n;
            if (m_lowrun >= c_RST) begin
                m_synced = 1'b1;
                m_lowcnt = c_RST;
            end
        end else begin
            old = m_lowcnt;
            m_lowcnt += n;
            if (old < c_RST && m_lowcnt >= c_RST) begin
                if (m_bits.size() != 0) begin
                    exp_err++;
                    m_bits.delete();
                end else if (m_seen) begin
                    exp_fe++;
                    m_seen = 1'b0;
                end
            end
        end
    endtask

    task automatic m_high(int n);
        logic [7:0] v;
`ifdef UNIPOLAR_RZ_GLITCH_FILTER_EN
        if (n < 3) begin
            m_low(n);
            return;
        end
`endif
        if (!m_synced) begin
            m_lowrun = 0;
        end else if (n >= c_MAXH) begin
            exp_err++;
            m_bits.delete();
            m_synced = 1'b0;
            m_lowrun = 0;
        end else begin
            m_bits.push_back(n > 6);
            m_lowcnt = 0;
            if (m_bits.size() == 8) begin
                v = 8'h00;
                for (int i = 0; i < 8; i++) v[i] = m_bits[i];
                exp_data.push_back(v);
                m_bits.delete();
                m_seen = 1'b1;
            end
        end
    endtask

    // Hold the line at lvl for exactly n sampling edges.
    task automatic seg(bit lvl, int n);
        if (lvl) m_high(n);
        else     m_low(n);
        line = lvl;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(bit b);
        seg(1'b1, b ? 8 : 4);
        seg(1'b0, b ? 4 : 8);
    endtask

    task automatic send_word(logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic send_word_rand(logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            seg(1'b1, w[i] ? int'($urandom_range(7, 15)) : int'($urandom_range(3, 6)));
            seg(1'b0, int'($urandom_range(3, 10)));
        end
    endtask

    task automatic clear_obs();
        act_data.delete();
        exp_data.delete();
        act_fe  = 0;
        act_err = 0;
        exp_fe  = 0;
        exp_err = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        line  = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        n_checks++; if (data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %0h expected 00", data); end
        n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (frame_end !== 1'b0) begin n_errors++; $display("FAIL reset_frame_end: got %b expected 0", frame_end); end
        n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL reset_error: got %b expected 0", error); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clock);
        #1 reset = 1'b0;
        m_reset();
        clear_obs();
    endtask

    task automatic test_single_word();
        clear_obs();
        seg(1'b0, 500);
        send_word(8'hA5);
        seg(1'b0, 20);
        n_checks++; if (act_data.size() !== 1) begin n_errors++; $display("FAIL single_valid_count: got %0d expected 1", act_data.size()); end
        if (act_data.size() > 0) begin
            n_checks++; if (act_data[0] !== 8'hA5) begin n_errors++; $display("FAIL single_data: got %0h expected a5", act_data[0]); end
        end
        n_checks++; if (act_err !== 0) begin n_errors++; $display("FAIL single_error: got %0d expected 0", act_err); end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_word(8'h01);
        send_word(8'hFF);
        seg(1'b0, 520);
        n_checks++; if (act_data.size() !== exp_data.size()) begin n_errors++; $display("FAIL b2b_valid_count: got %0d expected %0d", act_data.size(), exp_data.size()); end
        for (int i = 0; i < act_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (act_data[i] !== exp_data[i]) begin n_errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, act_data[i], exp_data[i]); end
        end
        n_checks++; if (act_fe !== exp_fe) begin n_errors++; $display("FAIL b2b_frame_end: got %0d expected %0d", act_fe, exp_fe); end
        n_checks++; if (act_err !== exp_err) begin n_errors++; $display("FAIL b2b_error: got %0d expected %0d", act_err, exp_err); end
    endtask

    task automatic test_truncated();
        clear_obs();
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        seg(1'b0, 520);
        n_checks++; if (act_err !== exp_err) begin n_errors++; $display("FAIL trunc_error: got %0d expected %0d", act_err, exp_err); end
        n_checks++; if (act_data.size() !== 0) begin n_errors++; $display("FAIL trunc_valid_count: got %0d expected 0", act_data.size()); end
        n_checks++; if (act_fe !== exp_fe) begin n_errors++; $display("FAIL trunc_frame_end: got %0d expected %0d", act_fe, exp_fe); end
        clear_obs();
        send_word(8'h3C);
        seg(1'b0, 20);
        n_checks++; if (act_data.size() !== exp_data.size()) begin n_errors++; $display("FAIL trunc_next_count: got %0d expected %0d", act_data.size(), exp_data.size()); end
        if (act_data.size() > 0 && exp_data.size() > 0) begin
            n_checks++; if (act_data[0] !== exp_data[0]) begin n_errors++; $display("FAIL trunc_next_data: got %0h expected %0h", act_data[0], exp_data[0]); end
        end
    endtask

    task automatic test_stuck_high();
        clear_obs();
        seg(1'b1, 20);
        seg(1'b0, 6);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        seg(1'b0, 520);
        send_word(8'h5A);
        seg(1'b0, 20);
        n_checks++; if (act_err !== exp_err) begin n_errors++; $display("FAIL stuck_error: got %0d expected %0d", act_err, exp_err); end
        n_checks++; if (act_data.size() !== exp_data.size()) begin n_errors++; $display("FAIL stuck_valid_count: got %0d expected %0d", act_data.size(), exp_data.size()); end
        for (int i = 0; i < act_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (act_data[i] !== exp_data[i]) begin n_errors++; $display("FAIL stuck_data[%0d]: got %0h expected %0h", i, act_data[i], exp_data[i]); end
        end
        n_checks++; if (act_fe !== exp_fe) begin n_errors++; $display("FAIL stuck_frame_end: got %0d expected %0d", act_fe, exp_fe); end
    endtask

    task automatic test_reset_mid_word();
        bit exp_busy;
        clear_obs();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        seg(1'b0, 6);
        exp_busy = m_synced && (m_bits.size() != 0);
        n_checks++; if (busy !== exp_busy) begin n_errors++; $display("FAIL midword_busy: got %b expected %b", busy, exp_busy); end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++; if (data !== 8'h00) begin n_errors++; $display("FAIL midreset_data: got %0h expected 00", data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL midreset_valid: got %b expected 0", valid); end
        @(posedge clock);
        #1 reset = 1'b0;
        m_reset();
        clear_obs();
        send_word(8'h77);
        seg(1'b0, 520);
        send_word(8'hC3);
        seg(1'b0, 20);
        n_checks++; if (act_data.size() !== exp_data.size()) begin n_errors++; $display("FAIL postreset_valid_count: got %0d expected %0d", act_data.size(), exp_data.size()); end
        for (int i = 0; i < act_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (act_data[i] !== exp_data[i]) begin n_errors++; $display("FAIL postreset_data[%0d]: got %0h expected %0h", i, act_data[i], exp_data[i]); end
        end
        n_checks++; if (act_err !== exp_err) begin n_errors++; $display("FAIL postreset_error: got %0d expected %0d", act_err, exp_err); end
    endtask

    task automatic test_threshold_glitch();
        int widths[8] = '{6, 7, 6, 7, 7, 6, 6, 7};
        clear_obs();
        foreach (widths[i]) begin
            seg(1'b1, widths[i]);
            seg(1'b0, 12 - widths[i]);
        end
        seg(1'b0, 20);
        seg(1'b1, 1);
        seg(1'b0, 6);
        send_word(8'hFF);
        seg(1'b0, 520);
        n_checks++; if (act_data.size() !== exp_data.size()) begin n_errors++; $display("FAIL thresh_valid_count: got %0d expected %0d", act_data.size(), exp_data.size()); end
        for (int i = 0; i < act_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (act_data[i] !== exp_data[i]) begin n_errors++; $display("FAIL thresh_data[%0d]: got %0h expected %0h", i, act_data[i], exp_data[i]); end
        end
        n_checks++; if (act_fe !== exp_fe) begin n_errors++; $display("FAIL thresh_frame_end: got %0d expected %0d", act_fe, exp_fe); end
        n_checks++; if (act_err !== exp_err) begin n_errors++; $display("FAIL thresh_error: got %0d expected %0d", act_err, exp_err); end
    endtask

    task automatic test_random_stream();
        clear_obs();
        for (int w = 0; w < 30; w++) begin
            if ($urandom_range(0, 9) == 0) begin
                seg(1'b1, int'($urandom_range(16, 30)));
                seg(1'b0, 5);
            end
            send_word_rand(8'($urandom));
            if ($urandom_range(0, 3) == 0) seg(1'b0, int'($urandom_range(520, 700)));
        end
        seg(1'b0, 520);
        n_checks++; if (act_data.size() !== exp_data.size()) begin n_errors++; $display("FAIL random_valid_count: got %0d expected %0d", act_data.size(), exp_data.size()); end
        for (int i = 0; i < act_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (act_data[i] !== exp_data[i]) begin n_errors++; $display("FAIL random_data[%0d]: got %0h expected %0h", i, act_data[i], exp_data[i]); end
        end
        n_checks++; if (act_fe !== exp_fe) begin n_errors++; $display("FAIL random_frame_end: got %0d expected %0d", act_fe, exp_fe); end
        n_checks++; if (act_err !== exp_err) begin n_errors++; $display("FAIL random_error: got %0d expected %0d", act_err, exp_err); end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_truncated();
        test_stuck_high();
        test_reset_mid_word();
        test_threshold_glitch();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
